// File: rtl/udp_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udp_tx_arbiter_if : requester, MAC and status signals of the arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface udp_tx_arbiter_if;
    logic        arp_req;
    logic        arp_ack;
    logic        cmd_req;
    logic [15:0] cmd_len;
    logic        cmd_ack;
    logic        ad_req;
    logic [15:0] ad_len;
    logic        ad_ack;
    logic        mac_send_end;
    logic        mac_not_exist;
    logic        udp_tx_req;
    logic        arp_request_req;
    logic [15:0] udp_send_data_length;
    logic [1:0]  tx_sel;
    logic        busy;
    logic        timeout_err;
    logic        abort_err;

    // Requesters and MAC side: drives requests and completion pulses
    modport master (
        output arp_req, cmd_req, cmd_len, ad_req, ad_len, mac_send_end, mac_not_exist,
        input  arp_ack, cmd_ack, ad_ack, udp_tx_req, arp_request_req,
        input  udp_send_data_length, tx_sel, busy, timeout_err, abort_err
    );

    modport slave (
        input  arp_req, cmd_req, cmd_len, ad_req, ad_len, mac_send_end, mac_not_exist,
        output arp_ack, cmd_ack, ad_ack, udp_tx_req, arp_request_req,
        output udp_send_data_length, tx_sel, busy, timeout_err, abort_err
    );
endinterface
`default_nettype wire

// File: rtl/udp_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udp_tx_arbiter : one-frame-at-a-time arbiter for ARP, command-reply  |
// | and AD frames onto the MAC, with inter-frame gap and timeout.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module udp_tx_arbiter #(
    parameter logic [15:0] IFG_CYCLES     = 16'd12,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
    parameter logic [15:0] LEN_MAX        = 16'd1472
) (
    input  logic            clk,
    input  logic            rst_n,
    udp_tx_arbiter_if.slave bus
);
    localparam logic [1:0] C_SEL_NONE = 2'b00;
    localparam logic [1:0] C_SEL_CMD  = 2'b01;
    localparam logic [1:0] C_SEL_AD   = 2'b10;
    localparam logic [1:0] C_SEL_ARP  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GRANT    = 2'd1,
        S_WAIT_END = 2'd2,
        S_GAP      = 2'd3
    } state_t;

    state_t      state_q;
    logic        last_cmd_q;
    logic [31:0] tmo_q;
    logic [15:0] gap_q;
    logic        arp_ack_q;
    logic        cmd_ack_q;
    logic        ad_ack_q;
    logic        udp_tx_req_q;
    logic        arp_request_req_q;
    logic [15:0] len_q;
    logic [1:0]  sel_q;
    logic        busy_q;
    logic        timeout_err_q;
    logic        abort_err_q;

    logic [1:0]  sel_d;
    logic [15:0] raw_len_d;
    logic [15:0] len_d;
    logic        tmo_hit_d;
    logic        gap_done_d;

    always_comb begin
        sel_d = C_SEL_NONE;
        if (bus.arp_req) begin
            sel_d = C_SEL_ARP;
        end else if (bus.cmd_req && bus.ad_req) begin
            sel_d = last_cmd_q ? C_SEL_AD : C_SEL_CMD;
        end else if (bus.cmd_req) begin
            sel_d = C_SEL_CMD;
        end else if (bus.ad_req) begin
            sel_d = C_SEL_AD;
        end

        case (sel_d)
            C_SEL_CMD: raw_len_d = bus.cmd_len;
            C_SEL_AD:  raw_len_d = bus.ad_len;
            default:   raw_len_d = 16'd0;
        endcase
        len_d = (raw_len_d > LEN_MAX) ? LEN_MAX : raw_len_d;
    end

    // Fires when the incremented count reaches TIMEOUT_CYCLES-1, so the
    // error pulse lands exactly TIMEOUT_CYCLES cycles after the GRANT cycle.
    assign tmo_hit_d  = ({1'b0, tmo_q} + 33'd2) >= {1'b0, TIMEOUT_CYCLES};
    assign gap_done_d = ({1'b0, gap_q} + 17'd1) >= {1'b0, IFG_CYCLES};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            last_cmd_q        <= 1'b0;
            tmo_q             <= 32'd0;
            gap_q             <= 16'd0;
            arp_ack_q         <= 1'b0;
            cmd_ack_q         <= 1'b0;
            ad_ack_q          <= 1'b0;
            udp_tx_req_q      <= 1'b0;
            arp_request_req_q <= 1'b0;
            len_q             <= 16'd0;
            sel_q             <= C_SEL_NONE;
            busy_q            <= 1'b0;
            timeout_err_q     <= 1'b0;
            abort_err_q       <= 1'b0;
        end else begin
            arp_ack_q         <= 1'b0;
            cmd_ack_q         <= 1'b0;
            ad_ack_q          <= 1'b0;
            udp_tx_req_q      <= 1'b0;
            arp_request_req_q <= 1'b0;
            timeout_err_q     <= 1'b0;
            abort_err_q       <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (sel_d != C_SEL_NONE) begin
                        state_q           <= S_GRANT;
                        busy_q            <= 1'b1;
                        sel_q             <= sel_d;
                        len_q             <= len_d;
                        arp_ack_q         <= (sel_d == C_SEL_ARP);
                        cmd_ack_q         <= (sel_d == C_SEL_CMD);
                        ad_ack_q          <= (sel_d == C_SEL_AD);
                        arp_request_req_q <= (sel_d == C_SEL_ARP);
                        udp_tx_req_q      <= (sel_d != C_SEL_ARP) && (len_d != 16'd0);
                    end
                end

                S_GRANT: begin
                    tmo_q <= 32'd0;
                    if (sel_q == C_SEL_CMD) begin
                        last_cmd_q <= 1'b1;
                    end else if (sel_q == C_SEL_AD) begin
                        last_cmd_q <= 1'b0;
                    end
                    // Zero-length UDP frames never reach the MAC
                    if ((sel_q != C_SEL_ARP) && (len_q == 16'd0)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        sel_q   <= C_SEL_NONE;
                    end else begin
                        state_q <= S_WAIT_END;
                    end
                end

                S_WAIT_END: begin
                    gap_q <= 16'd0;
                    if (bus.mac_send_end) begin
                        state_q <= S_GAP;
                    end else if (bus.mac_not_exist) begin
                        state_q     <= S_GAP;
                        abort_err_q <= 1'b1;
                    end else if (tmo_hit_d) begin
                        state_q       <= S_GAP;
                        timeout_err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end

                S_GAP: begin
                    if (gap_done_d) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        sel_q   <= C_SEL_NONE;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    sel_q   <= C_SEL_NONE;
                end
            endcase
        end
    end

    assign bus.arp_ack              = arp_ack_q;
    assign bus.cmd_ack              = cmd_ack_q;
    assign bus.ad_ack               = ad_ack_q;
    assign bus.udp_tx_req           = udp_tx_req_q;
    assign bus.arp_request_req      = arp_request_req_q;
    assign bus.udp_send_data_length = len_q;
    assign bus.tx_sel               = sel_q;
    assign bus.busy                 = busy_q;
    assign bus.timeout_err          = timeout_err_q;
    assign bus.abort_err            = abort_err_q;
endmodule
`default_nettype wire

// File: tb/tb_udp_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_udp_tx_arbiter : directed and randomized frames against a         |
// | transaction-level model of the transmit arbiter.  Rev 1.0            |
// +----------------------------------------------------------------------+
module tb_udp_tx_arbiter;
    localparam int IFG  = 12;
    localparam int TMO  = 50;
    localparam int LMAX = 1472;

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    bit   m_last_cmd;

    udp_tx_arbiter_if bus();

    udp_tx_arbiter #(
        .IFG_CYCLES     (16'(IFG)),
        .TIMEOUT_CYCLES (32'(TMO)),
        .LEN_MAX        (16'(LMAX))
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] out_vec();
        return {bus.arp_ack, bus.cmd_ack, bus.ad_ack, bus.udp_tx_req, bus.arp_request_req,
                bus.busy, bus.timeout_err, bus.abort_err, bus.tx_sel, bus.udp_send_data_length};
    endfunction

    // cmd is eligible unless ad is also waiting and cmd had the last turn
    function automatic logic [1:0] pick();
        if (bus.arp_req) return 2'd3;
        if (bus.cmd_req && (!bus.ad_req || !m_last_cmd)) return 2'd1;
        if (bus.ad_req) return 2'd2;
        return 2'd0;
    endfunction

    // mode: 0 send_end, 1 not_exist, 2 timeout, 3 send_end on the timeout cycle
    // drop: 0 drop served request, 1 keep all, 2 drop all
    task automatic do_frame(input int mode, input int drop, input bit stray);
        logic [1:0] es;
        int         el;
        int         n;
        bit         got;
        es = pick();
        el = (es == 2'd1) ? int'(bus.cmd_len) : (es == 2'd2) ? int'(bus.ad_len) : 0;
        if (el > LMAX) el = LMAX;

        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            got = bus.arp_ack | bus.cmd_ack | bus.ad_ack;
        end
        chk("grant_seen", 32'(got), 32'd1);
        if (!got) return;
        chk("tx_sel", 32'(bus.tx_sel), 32'(es));
        chk("length", 32'(bus.udp_send_data_length), 32'(el));
        chk("acks", 32'({bus.arp_ack, bus.cmd_ack, bus.ad_ack}),
            32'({es == 2'd3, es == 2'd1, es == 2'd2}));
        chk("strobes", 32'({bus.arp_request_req, bus.udp_tx_req}),
            32'({es == 2'd3, (es != 2'd3) && (el != 0)}));
        chk("busy_grant", 32'(bus.busy), 32'd1);

        if (es == 2'd1) m_last_cmd = 1'b1;
        else if (es == 2'd2) m_last_cmd = 1'b0;
        if (drop == 2) begin
            bus.arp_req = 1'b0; bus.cmd_req = 1'b0; bus.ad_req = 1'b0;
        end else if (drop == 0) begin
            if (es == 2'd3) bus.arp_req = 1'b0;
            else if (es == 2'd1) bus.cmd_req = 1'b0;
            else bus.ad_req = 1'b0;
        end

        if ((es != 2'd3) && (el == 0)) begin
            tick();
            chk("zero_len_idle", 32'({bus.busy, bus.tx_sel, bus.udp_tx_req}), 32'd0);
            return;
        end

        // A completion pulse during GRANT must be ignored
        bus.mac_send_end = stray;
        tick();
        bus.mac_send_end = 1'b0;

        if (mode == 2) begin
            n = 1;
            while (!bus.timeout_err && n < 200) begin
                tick();
                n++;
            end
            chk("timeout_at", 32'(n), 32'(TMO));
            chk("abort_on_tmo", 32'(bus.abort_err), 32'd0);
        end else begin
            if (mode == 3) repeat (TMO - 2) tick();
            else repeat ($urandom_range(0, 30)) tick();
            if (mode == 1) bus.mac_not_exist = 1'b1;
            else bus.mac_send_end = 1'b1;
            tick();
            bus.mac_send_end  = 1'b0;
            bus.mac_not_exist = 1'b0;
            chk("abort_err", 32'(bus.abort_err), 32'(mode == 1));
            chk("timeout_err", 32'(bus.timeout_err), 32'd0);
        end
        chk("busy_gap", 32'(bus.busy), 32'd1);

        n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        chk("gap_len", 32'(n), 32'(IFG));
        chk("tx_sel_idle", 32'(bus.tx_sel), 32'd0);
    endtask

    initial begin
        bit got;
        int guard;
        rst_n             = 1'b0;
        bus.arp_req       = 1'b0;
        bus.cmd_req       = 1'b0;
        bus.ad_req        = 1'b0;
        bus.cmd_len       = 16'd0;
        bus.ad_len        = 16'd0;
        bus.mac_send_end  = 1'b0;
        bus.mac_not_exist = 1'b0;
        m_last_cmd        = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 32'(out_vec()), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", 32'(out_vec()), 32'd0);

        // Simultaneous requests: ARP, then cmd, then ad
        bus.cmd_len = 16'd200; bus.ad_len = 16'd300;
        bus.arp_req = 1'b1; bus.cmd_req = 1'b1; bus.ad_req = 1'b1;
        do_frame(0, 0, 1'b1);
        do_frame(0, 0, 1'b0);
        do_frame(0, 0, 1'b0);

        // Single cmd frame with length 100
        bus.cmd_len = 16'd100; bus.cmd_req = 1'b1;
        do_frame(0, 0, 1'b0);

        // cmd and ad held for four frames
        bus.cmd_len = 16'd64; bus.ad_len = 16'd512;
        bus.cmd_req = 1'b1; bus.ad_req = 1'b1;
        do_frame(0, 1, 1'b0);
        do_frame(0, 1, 1'b0);
        do_frame(0, 1, 1'b0);
        do_frame(0, 2, 1'b0);

        // Length clamp
        bus.ad_len = 16'd2000; bus.ad_req = 1'b1;
        do_frame(0, 0, 1'b0);
        bus.cmd_len = 16'hFFFF; bus.cmd_req = 1'b1;
        do_frame(0, 0, 1'b0);

        // Timeout, abort, and completion coinciding with timeout
        bus.cmd_len = 16'd40; bus.cmd_req = 1'b1;
        do_frame(2, 0, 1'b1);
        bus.ad_len = 16'd1472; bus.ad_req = 1'b1;
        do_frame(1, 0, 1'b0);
        bus.arp_req = 1'b1;
        do_frame(3, 0, 1'b0);

        // Zero-length request
        bus.cmd_len = 16'd0; bus.cmd_req = 1'b1;
        do_frame(0, 0, 1'b0);
        bus.ad_len = 16'd10; bus.ad_req = 1'b1;
        do_frame(0, 0, 1'b0);

        // Reset during WAIT_END
        bus.cmd_len = 16'd300; bus.cmd_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = bus.cmd_ack;
        end
        chk("rst_pre_grant", 32'(got), 32'd1);
        bus.cmd_req = 1'b0;
        repeat (3) tick();
        chk("rst_pre_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 32'(out_vec()), 32'd0);
        m_last_cmd = 1'b0;
        bus.ad_len = 16'd64; bus.ad_req = 1'b1;
        tick();
        tick();
        chk("rst_held_outputs", 32'(out_vec()), 32'd0);
        rst_n = 1'b1;
        do_frame(0, 0, 1'b0);

        // Randomized request patterns
        for (int r = 0; r < 12; r++) begin
            bus.arp_req = ($urandom_range(0, 3) == 0);
            bus.cmd_req = 1'($urandom_range(0, 1));
            bus.ad_req  = 1'($urandom_range(0, 1));
            if (!bus.arp_req && !bus.ad_req) bus.cmd_req = 1'b1;
            case ($urandom_range(0, 7))
                0:       bus.cmd_len = 16'd0;
                1:       bus.cmd_len = 16'($urandom_range(1473, 4000));
                default: bus.cmd_len = 16'($urandom_range(1, 1472));
            endcase
            case ($urandom_range(0, 7))
                0:       bus.ad_len = 16'd0;
                1:       bus.ad_len = 16'($urandom_range(1473, 65535));
                default: bus.ad_len = 16'($urandom_range(1, 1472));
            endcase
            guard = 0;
            while ((bus.arp_req || bus.cmd_req || bus.ad_req) && guard < 6) begin
                do_frame(int'($urandom_range(0, 3)), 0, 1'($urandom_range(0, 1)));
                guard++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/udp_tx_arbiter.md
# udp_tx_arbiter

Transmit arbiter that shares the single MAC transmit path among three requesters: ARP request generation, command-reply frames and AD sample-data frames. It sits between the command and data producers and the MAC. Its job is to:
- sequence exactly one frame at a time;
- drive the MAC's `udp_tx_req` / `arp_request_req` strobes and the frame length;
- steer the payload mux with `tx_sel`;
- enforce an inter-frame gap and a completion timeout.

## Interface

Parameters
- `IFG_CYCLES`, 16'd12: idle cycles enforced after each frame completes.
- `TIMEOUT_CYCLES`, 32'd1000000: maximum cycles to wait for frame completion.
- `LEN_MAX`, 16'd1472: largest legal UDP payload length; longer requests are clamped to this value.

Ports
- `clk` in 1: transmit clock. All logic runs on this single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `arp_req` in 1: level request to send an ARP request.
- `arp_ack` out 1: one-cycle grant for ARP.
- `cmd_req` in 1: level request for a command-reply frame.
- `cmd_len` in 16: command-reply payload length in bytes. Must be stable while `cmd_req` is high.
- `cmd_ack` out 1: one-cycle grant for the command reply.
- `ad_req` in 1: level request for an AD data frame.
- `ad_len` in 16: AD payload length in bytes. Must be stable while `ad_req` is high.
- `ad_ack` out 1: one-cycle grant for AD data.
- `mac_send_end` in 1: one-cycle pulse from the MAC indicating the frame is fully transmitted.
- `mac_not_exist` in 1: one-cycle pulse from the MAC indicating the UDP frame was aborted because there is no ARP entry.
- `udp_tx_req` out 1: one-cycle UDP transmit strobe to the MAC.
- `arp_request_req` out 1: one-cycle ARP transmit strobe to the MAC.
- `udp_send_data_length` out 16: latched, clamped length of the frame in service.
- `tx_sel` out 2: payload source select. 00 = none, 01 = cmd, 10 = ad, 11 = arp.
- `busy` out 1: high in every state except IDLE.
- `timeout_err` out 1: one-cycle pulse when a frame is abandoned on timeout.
- `abort_err` out 1: one-cycle pulse when `mac_not_exist` ends a frame.

## Operation

The arbiter is a four-state FSM: IDLE, GRANT, WAIT_END, GAP.

**IDLE**
- Evaluate the requests in fixed order:
  1. `arp_req` always wins.
  2. If `cmd_req` and `ad_req` are both high, round-robin using the `last_cmd` flag: serve ad if `last_cmd`=1, otherwise serve cmd.
  3. A single pending UDP request is served directly.
- On selecting a winner:
  - Latch `tx_sel`.
  - Latch `udp_send_data_length` = min(len, `LEN_MAX`). For ARP the length is 0.
  - Go to GRANT.
- A UDP request with len = 0:
  - Pulses its ack in the following cycle.
  - Updates `last_cmd`.
  - Returns to IDLE with no MAC strobe.

**GRANT (exactly one cycle)**
- Assert the matching MAC strobe and the matching ack.
- Update `last_cmd`: 1 if cmd was served, 0 if ad was served, unchanged for ARP.
- Clear the timeout counter.
- Go to WAIT_END.

**WAIT_END**
- The timeout counter increments every cycle.
- `mac_send_end` → GAP.
- `mac_not_exist` → GAP, with `abort_err` pulsed.
- Counter reaches `TIMEOUT_CYCLES-1` → GAP, with `timeout_err` pulsed.
- If completion and timeout coincide, completion wins and no error is pulsed.

**GAP**
- Hold for `IFG_CYCLES` cycles, then go to IDLE.
- Clear `tx_sel` to 00 on entry to IDLE.
- With `IFG_CYCLES`=0, go from GAP to IDLE after one cycle.

**Requester rules**
- Drop `req` within `IFG_CYCLES` cycles of receiving ack. A request still high on return to IDLE is treated as a new request.
- Requests arriving during GRANT, WAIT_END or GAP are not lost. Because they are level signals, they are evaluated on return to IDLE.

**Ignored inputs**
- `mac_send_end` and `mac_not_exist` are ignored outside WAIT_END, including in the GRANT cycle.

## Timing

**Reset values**
- All outputs are 0: acks, strobes, `udp_send_data_length`, `tx_sel`, `busy`, `timeout_err`, `abort_err`.
- FSM = IDLE, `last_cmd` = 0 (so cmd is served first on a tie), counters = 0.

**Latency**
- If a request is sampled high in IDLE at edge k:
  - GRANT is the cycle after edge k. The strobe, ack, `tx_sel` and length all become valid together, registered.
  - `udp_send_data_length` and `tx_sel` are held until the return to IDLE.
- From a `mac_send_end` pulse to the next possible strobe: `IFG_CYCLES` + 2 cycles.

**Reset mid-operation**
- Asynchronous return to the reset values.
- Any in-flight frame is forgotten. No ack or error is generated.

**Widths**
- The length comparison is unsigned 16-bit.
- The timeout counter is 32-bit.
- The gap counter is 16-bit.

## Test plan

1. `cmd_req`=1 with `cmd_len`=100 → next cycle: `udp_tx_req`=1, `cmd_ack`=1, `tx_sel`=01, length=100. `mac_send_end` pulse → `busy` falls 13 cycles later (`IFG_CYCLES`=12).
2. `arp_req`, `cmd_req` and `ad_req` asserted in the same cycle, each dropped after its ack → order ARP, cmd, ad. `arp_request_req` pulses with length 0.
3. cmd and ad held continuously for 4 frames → grants alternate cmd, ad, cmd, ad.
4. `ad_len`=2000 → `udp_send_data_length`=1472.
5. No `mac_send_end`, `TIMEOUT_CYCLES`=50 → `timeout_err` pulses exactly 50 cycles after GRANT, then GAP. A `mac_not_exist` pulse instead → `abort_err` pulses.
6. Reset asserted during WAIT_END → all outputs 0 immediately. After release, a pending `ad_req` is re-granted normally.
